amp_adc_controller: RTL and testbench

Sequencing controller for the amplifier/ADC front end. After reset it issues one gain-programming request to the preamplifier serial interface and waits for completion. It then loops forever: start an ADC conversion, wait for it to finish, and capture both 8-bit channel results. It sits between the top-level control logic and the amplifier and ADC serial engines, and drives the shared serial-bus mux select.

---
 rtl/amp_adc_controller_if.sv | 22 ++
 rtl/amp_adc_controller.sv | 98 +++++++++
 tb/tb_amp_adc_controller.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/amp_adc_controller_if.sv
// Handshake bundle between the amplifier/ADC sequencing controller and the serial engines.
interface amp_adc_controller_if;
    logic       DONE_AMP;
    logic       DONE_ADC;
    logic [7:0] ADC0;
    logic [7:0] ADC1;
    logic       GO_AMP;
    logic       GO_ADC;
    logic [7:0] T;
    logic [7:0] L;
    logic [1:0] select;

    modport master (
        input  DONE_AMP, DONE_ADC, ADC0, ADC1,
        output GO_AMP, GO_ADC, T, L, select
    );

    modport slave (
        output DONE_AMP, DONE_ADC, ADC0, ADC1,
        input  GO_AMP, GO_ADC, T, L, select
    );
endinterface

// File: rtl/amp_adc_controller.sv
// Programs the preamp gain once per reset, then loops ADC conversions and latches both channels.
// Optional inter-conversion pacing is compiled in with `define AMP_ADC_CTRL_PACING_EN.
module amp_adc_controller #(
    parameter int SAMPLE_GAP = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    amp_adc_controller_if.master        bus
);

    typedef enum logic [2:0] {
        IDLE,
        AMP_GO,
        AMP_WAIT,
        ADC_GO,
        ADC_WAIT,
        GAP
    } state_t;

    state_t state;

    generate
        if (SAMPLE_GAP < 1 || SAMPLE_GAP > 255) begin : g_gap_range
            $error("SAMPLE_GAP must be in 1..255");
        end
    endgenerate

`ifdef AMP_ADC_CTRL_PACING_EN
    logic [7:0] gap_cnt;
`endif

    // Outputs are assigned alongside the state they belong to, so every output is a register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            bus.GO_AMP  <= 1'b0;
            bus.GO_ADC  <= 1'b0;
            bus.T       <= 8'd0;
            bus.L       <= 8'd0;
            bus.select  <= 2'b00;
`ifdef AMP_ADC_CTRL_PACING_EN
            gap_cnt     <= 8'd0;
`endif
        end else begin
            bus.GO_AMP <= 1'b0;
            bus.GO_ADC <= 1'b0;
            case (state)
                IDLE: begin
                    state      <= AMP_GO;
                    bus.GO_AMP <= 1'b1;
                    bus.select <= 2'b01;
                end
                AMP_GO: begin
                    state <= AMP_WAIT;
                end
                AMP_WAIT: begin
                    if (bus.DONE_AMP) begin
                        state      <= ADC_GO;
                        bus.GO_ADC <= 1'b1;
                        bus.select <= 2'b10;
                    end
                end
                ADC_GO: begin
                    state <= ADC_WAIT;
                end
                ADC_WAIT: begin
                    if (bus.DONE_ADC) begin
                        bus.T <= bus.ADC0;
                        bus.L <= bus.ADC1;
`ifdef AMP_ADC_CTRL_PACING_EN
                        state   <= GAP;
                        gap_cnt <= 8'(SAMPLE_GAP);
`else
                        state      <= ADC_GO;
                        bus.GO_ADC <= 1'b1;
`endif
                    end
                end
`ifdef AMP_ADC_CTRL_PACING_EN
                GAP: begin
                    // The load value counts as the first gap cycle, so exit on 1.
                    if (gap_cnt == 8'd1) begin
                        state      <= ADC_GO;
                        bus.GO_ADC <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
`endif
                default: begin
                    state      <= IDLE;
                    bus.select <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_amp_adc_controller.sv
// Directed plus randomized bench for amp_adc_controller, checked against a transaction-level model.
module tb_amp_adc_controller;

    localparam int TB_GAP = 4;
`ifdef AMP_ADC_CTRL_PACING_EN
    localparam int GAP_CYC = TB_GAP;
`else
    localparam int GAP_CYC = 0;
`endif

    logic clk;
    logic rst_n;
    amp_adc_controller_if bus();

    amp_adc_controller #(.SAMPLE_GAP(TB_GAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    // Reference model: which engine owns the bus, when its request went out, and pause time left.
    int       edgeNo   = 0;
    bit       started  = 0;
    int       owner    = 0;
    int       issuedAt = 0;
    int       pauseLeft = 0;
    bit       expGoAmp = 0;
    bit       expGoAdc = 0;
    int       expT     = 0;
    int       expL     = 0;
    int       expSel   = 0;
    int       goAmpCount = 0;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %0d, want %0d", tag, $time, actual, expected);
        end
    endtask

    task automatic modelEdge(input bit r, input bit dAmp, input bit dAdc,
                             input int a0, input int a1);
        edgeNo++;
        expGoAmp = 0;
        expGoAdc = 0;
        if (!r) begin
            started = 0; owner = 0; pauseLeft = 0;
            expT = 0; expL = 0; expSel = 0;
        end else if (!started) begin
            started = 1; owner = 1; issuedAt = edgeNo;
            expGoAmp = 1; expSel = 1;
        end else if (pauseLeft > 0) begin
            pauseLeft--;
            if (pauseLeft == 0) begin
                expGoAdc = 1; issuedAt = edgeNo;
            end
        end else if (edgeNo >= issuedAt + 2) begin
            // A request is answerable only after its pulse cycle and one wait cycle have passed.
            if (owner == 1 && dAmp) begin
                owner = 2; expSel = 2; expGoAdc = 1; issuedAt = edgeNo;
            end else if (owner == 2 && dAdc) begin
                expT = a0; expL = a1;
                if (GAP_CYC == 0) begin
                    expGoAdc = 1; issuedAt = edgeNo;
                end else begin
                    pauseLeft = GAP_CYC;
                end
            end
        end
    endtask

    task automatic applyStimulus(input bit r, input bit dAmp, input bit dAdc,
                                 input int a0, input int a1);
        rst_n        = r;
        bus.DONE_AMP = dAmp;
        bus.DONE_ADC = dAdc;
        bus.ADC0     = 8'(a0);
        bus.ADC1     = 8'(a1);
        modelEdge(r, dAmp, dAdc, a0, a1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("GO_AMP", int'(bus.GO_AMP), int'(expGoAmp));
        checkOutput("GO_ADC", int'(bus.GO_ADC), int'(expGoAdc));
        checkOutput("T",      int'(bus.T),      expT);
        checkOutput("L",      int'(bus.L),      expL);
        checkOutput("select", int'(bus.select), expSel);
        if (bus.GO_AMP === 1'b1) goAmpCount++;
    endtask

    initial begin
        int dAmpBias;
        int dAdcBias;
        rst_n = 1'b0;
        bus.DONE_AMP = 1'b1;
        bus.DONE_ADC = 1'b1;
        bus.ADC0 = 8'd0;
        bus.ADC1 = 8'd0;

        // Reset held with both DONE inputs high
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 55, 66);

        // Startup handshake, amplifier completes a few cycles late
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, 100, 230);
        checkOutput("T_before_capture", int'(bus.T), 0);

        // Capture after a delayed conversion completion
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 100, 230);
        applyStimulus(1, 0, 1, 100, 230);
        checkOutput("T_capture", int'(bus.T), 100);
        checkOutput("L_capture", int'(bus.L), 230);

        // Free-run with both DONE inputs stuck high
        goAmpCount = 0;
        for (int i = 0; i < 12; i++) applyStimulus(1, 1, 1, 100, 230);
        for (int i = 0; i < 2 + 2 * GAP_CYC + 6; i++) applyStimulus(1, 1, 1, 7, 8);
        checkOutput("T_follow", int'(bus.T), 7);
        checkOutput("L_follow", int'(bus.L), 8);
        checkOutput("GO_AMP_once", goAmpCount, 0);

        // Reset for one cycle while a conversion is outstanding
        applyStimulus(1, 0, 0, 9, 9);
        applyStimulus(1, 0, 0, 9, 9);
        applyStimulus(0, 0, 0, 9, 9);
        goAmpCount = 0;
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 9, 9);
        checkOutput("GO_AMP_after_reset", goAmpCount, 1);

        // Randomized run with varying DONE density and occasional resets
        for (int blk = 0; blk < 20; blk++) begin
            dAmpBias = int'($urandom_range(1, 4));
            dAdcBias = int'($urandom_range(1, 4));
            for (int i = 0; i < 100; i++) begin
                applyStimulus(($urandom_range(0, 59) != 0),
                              ($urandom_range(0, 3) < dAmpBias),
                              ($urandom_range(0, 3) < dAdcBias),
                              int'($urandom_range(0, 255)),
                              int'($urandom_range(0, 255)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
